// File: rtl/rocket_pkg.sv
// Shared constants and state encodings for the rocket control FSM and its draw datapath.
package rocket_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int ROCKET_WIDTH  = 8;
  localparam int ROCKET_HEIGHT = 4;
  localparam int ROCKET_TOP    = 112;
  localparam int BASE_TOP      = 118;
  localparam int MOVE_STEP     = 2;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [3:0] {
    DP_IDLE,
    DP_CLEAR,
    DP_CLEAR_ACK,
    DP_BASE,
    DP_BASE_ROCKET,
    DP_BASE_ACK,
    DP_ERASE,
    DP_DRAW,
    DP_MOVE_END
  } dp_state_t;

  typedef enum logic [2:0] {
    CTRL_RESET,
    CTRL_CLEAR,
    CTRL_HOMEBASE,
    CTRL_WAIT,
    CTRL_MOVE
  } ctrl_state_t;

endpackage

// File: rtl/rect_scanner.sv
// Walks a rectangle one pixel per cycle, x fastest; a new start restarts the walk immediately.
module rect_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ox,
  input  logic [6:0] oy,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       valid,
  output logic       done,
  output logic       last
);

  logic [7:0] x0;
  logic [7:0] x_end;
  logic [6:0] y_end;

  // last lets the owner chain the next rectangle without a gap cycle
  assign last = valid && (x == x_end) && (y == y_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      x0    <= '0;
      x_end <= '0;
      y_end <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x     <= ox;
        y     <= oy;
        x0    <= ox;
        x_end <= ox + w - 8'd1;
        y_end <= oy + h - 7'd1;
        valid <= 1'b1;
      end else if (valid) begin
        if (x == x_end) begin
          x <= x0;
          if (y == y_end) begin
            valid <= 1'b0;
            done  <= 1'b1;
          end else begin
            y <= y + 7'd1;
          end
        end else begin
          x <= x + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/rocket_draw_datapath.sv
// Executes clear / homebase / move commands and streams registered pixel writes to the VGA adapter.
module rocket_draw_datapath
  import rocket_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_WIDTH,
  parameter int SCREEN_H = SCREEN_HEIGHT,
  parameter int ROCKET_W = ROCKET_WIDTH,
  parameter int ROCKET_H = ROCKET_HEIGHT,
  parameter int ROCKET_Y = ROCKET_TOP,
  parameter int BASE_Y   = BASE_TOP,
  parameter int STEP     = MOVE_STEP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearEnable,
  input  logic       drawHomebase,
  input  logic       moveLeft,
  input  logic       moveRight,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       screenCleared,
  output logic       drewHomebase,
  output logic       moveDone,
  output logic       busy,
  output logic [7:0] rocket_x
);

  localparam logic [7:0] HOME_X = 8'((SCREEN_W - ROCKET_W) / 2);
  localparam logic [7:0] MAX_X  = 8'(SCREEN_W - ROCKET_W);
  localparam logic [8:0] STEP9  = 9'(STEP);

  dp_state_t  state;
  logic [7:0] target_x;
  logic [2:0] pen;

  logic       scan_start;
  logic [7:0] scan_ox;
  logic [6:0] scan_oy;
  logic [7:0] scan_w;
  logic [6:0] scan_h;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic       scan_valid;
  logic       scan_done;
  logic       scan_last;

  logic       move_one;
  logic       clear_abort;
  logic [8:0] left9;
  logic [8:0] right9;
  logic [7:0] move_x;

  assign move_one = moveLeft ^ moveRight;
  // 9-bit sums so a left step from 0 goes negative instead of wrapping
  assign left9  = {1'b0, rocket_x} - STEP9;
  assign right9 = {1'b0, rocket_x} + STEP9;
  assign clear_abort = clearEnable && (state inside {DP_ERASE, DP_DRAW, DP_MOVE_END});

  always_comb begin
    move_x = rocket_x;
    if (moveLeft)
      move_x = left9[8] ? 8'd0 : left9[7:0];
    else if (right9 > {1'b0, MAX_X})
      move_x = MAX_X;
    else
      move_x = right9[7:0];
  end

  always_comb begin
    scan_start = 1'b0;
    scan_ox    = '0;
    scan_oy    = '0;
    scan_w     = 8'(ROCKET_W);
    scan_h     = 7'(ROCKET_H);
    if (clearEnable && (state == DP_IDLE || clear_abort)) begin
      scan_start = 1'b1;
      scan_w     = 8'(SCREEN_W);
      scan_h     = 7'(SCREEN_H);
    end else begin
      case (state)
        DP_IDLE: begin
          if (drawHomebase) begin
            scan_start = 1'b1;
            scan_oy    = 7'(BASE_Y);
            scan_w     = 8'(SCREEN_W);
            scan_h     = 7'd2;
          end else if (move_one && move_x != rocket_x) begin
            scan_start = 1'b1;
            scan_ox    = rocket_x;
            scan_oy    = 7'(ROCKET_Y);
          end
        end
        DP_BASE: begin
          scan_start = scan_last;
          scan_ox    = rocket_x;
          scan_oy    = 7'(ROCKET_Y);
        end
        DP_ERASE: begin
          scan_start = scan_last;
          scan_ox    = target_x;
          scan_oy    = 7'(ROCKET_Y);
        end
        default: ;
      endcase
    end
  end

  rect_scanner u_scan (
    .clk   (clk),
    .reset (reset),
    .start (scan_start),
    .ox    (scan_ox),
    .oy    (scan_oy),
    .w     (scan_w),
    .h     (scan_h),
    .x     (scan_x),
    .y     (scan_y),
    .valid (scan_valid),
    .done  (scan_done),
    .last  (scan_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= DP_IDLE;
      target_x      <= HOME_X;
      pen           <= BLACK;
      rocket_x      <= HOME_X;
      x             <= '0;
      y             <= '0;
      colour        <= BLACK;
      plot          <= 1'b0;
      busy          <= 1'b0;
      screenCleared <= 1'b0;
      drewHomebase  <= 1'b0;
      moveDone      <= 1'b0;
    end else begin
      x        <= scan_x;
      y        <= scan_y;
      colour   <= pen;
      // the pixel in flight when a clear aborts a move is dropped
      plot     <= scan_valid && !clear_abort;
      busy     <= scan_valid && !clear_abort;
      moveDone <= 1'b0;
      case (state)
        DP_IDLE: begin
          if (clearEnable) begin
            state <= DP_CLEAR;
            pen   <= BLACK;
          end else if (drawHomebase) begin
            state    <= DP_BASE;
            pen      <= GREEN;
            rocket_x <= HOME_X;
          end else if (move_one) begin
            target_x <= move_x;
            if (move_x == rocket_x) begin
              state    <= DP_MOVE_END;
              moveDone <= 1'b1;
            end else begin
              state <= DP_ERASE;
              pen   <= BLACK;
            end
          end
        end
        DP_CLEAR: begin
          if (scan_done) begin
            state         <= DP_CLEAR_ACK;
            screenCleared <= 1'b1;
          end
        end
        DP_CLEAR_ACK: begin
          if (!clearEnable) begin
            state         <= DP_IDLE;
            screenCleared <= 1'b0;
          end
        end
        DP_BASE: begin
          if (scan_last) begin
            state <= DP_BASE_ROCKET;
            pen   <= WHITE;
          end
        end
        DP_BASE_ROCKET: begin
          if (scan_done) begin
            state        <= DP_BASE_ACK;
            drewHomebase <= 1'b1;
          end
        end
        DP_BASE_ACK: begin
          if (!drawHomebase) begin
            state        <= DP_IDLE;
            drewHomebase <= 1'b0;
          end
        end
        DP_ERASE: begin
          if (clearEnable) begin
            state <= DP_CLEAR;
            pen   <= BLACK;
          end else if (scan_last) begin
            state    <= DP_DRAW;
            pen      <= WHITE;
            rocket_x <= target_x;
          end
        end
        DP_DRAW: begin
          if (clearEnable) begin
            state <= DP_CLEAR;
            pen   <= BLACK;
          end else if (scan_done) begin
            state    <= DP_MOVE_END;
            moveDone <= 1'b1;
          end
        end
        DP_MOVE_END: begin
          if (clearEnable) begin
            state <= DP_CLEAR;
            pen   <= BLACK;
          end else begin
            state <= DP_IDLE;
          end
        end
        default: state <= DP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rocket_draw_datapath.sv
// Directed bench for rocket_draw_datapath: pixel streams, handshakes, saturation and aborts.
module tb_rocket_draw_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clearEnable = 1'b0;
  logic       drawHomebase = 1'b0;
  logic       moveLeft = 1'b0;
  logic       moveRight = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       screenCleared;
  logic       drewHomebase;
  logic       moveDone;
  logic       busy;
  logic [7:0] rocket_x;

  int checks = 0;
  int errors = 0;
  int qx[$];
  int qy[$];
  int qc[$];
  int qcyc[$];
  int ack_cyc;
  int busy_bad;

  rocket_draw_datapath dut (
    .clk           (clk),
    .reset         (reset),
    .clearEnable   (clearEnable),
    .drawHomebase  (drawHomebase),
    .moveLeft      (moveLeft),
    .moveRight     (moveRight),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .screenCleared (screenCleared),
    .drewHomebase  (drewHomebase),
    .moveDone      (moveDone),
    .busy          (busy),
    .rocket_x      (rocket_x)
  );

  always #5 clk = ~clk;

  // Records plots (with cycle index, 1 = first negedge after the request edge) until an ack appears.
  task automatic collect(input int max_cyc);
    qx.delete(); qy.delete(); qc.delete(); qcyc.delete();
    ack_cyc  = -1;
    busy_bad = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) begin moveLeft = 1'b0; moveRight = 1'b0; end
      if (busy !== plot) busy_bad++;
      if (plot === 1'b1) begin
        qx.push_back(int'(x)); qy.push_back(int'(y)); qc.push_back(int'(colour)); qcyc.push_back(c);
      end
      if (screenCleared === 1'b1 || drewHomebase === 1'b1 || moveDone === 1'b1) begin
        ack_cyc = c;
        break;
      end
    end
    checks++;
    if (ack_cyc < 0) begin
      errors++;
      $display("FAIL collect_timeout: no ack within %0d cycles, plots seen %0d", max_cyc, qx.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", plot); end
    checks++; if (x !== 8'd0 || y !== 7'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); end
    checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %b want 000", colour); end
    checks++; if ({screenCleared, drewHomebase, moveDone, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {screenCleared, drewHomebase, moveDone, busy});
    end
    checks++; if (rocket_x !== 8'd76) begin errors++; $display("FAIL reset_rocket_x: got %0d want 76", rocket_x); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int bad;
    int n;
    clearEnable = 1'b1;
    collect(20000);
    n = qx.size();
    bad = 0;
    for (int i = 0; i < n; i++)
      if (qx[i] != i % 160 || qy[i] != i / 160 || qc[i] != 0 || qcyc[i] != i + 2) bad++;
    checks++; if (n != 19200) begin errors++; $display("FAIL clear_count: got %0d want 19200", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_stream: %0d pixels off order/colour/timing, want 0", bad); end
    if (n > 0) begin
      checks++; if (qx[n-1] != 159 || qy[n-1] != 119) begin
        errors++; $display("FAIL clear_last: got %0d,%0d want 159,119", qx[n-1], qy[n-1]);
      end
      checks++; if (ack_cyc != qcyc[n-1] + 1) begin
        errors++; $display("FAIL clear_ack_time: got cycle %0d want %0d", ack_cyc, qcyc[n-1] + 1);
      end
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL clear_busy: %0d cycles busy!=plot, want 0", busy_bad); end
    repeat (3) @(negedge clk);
    checks++; if (screenCleared !== 1'b1) begin errors++; $display("FAIL clear_ack_hold: got %b want 1", screenCleared); end
    clearEnable = 1'b0;
    @(negedge clk);
    checks++; if (screenCleared !== 1'b0) begin errors++; $display("FAIL clear_ack_drop: got %b want 0", screenCleared); end
    @(negedge clk);
  endtask

  task automatic test_homebase();
    int bad;
    int n;
    int ex, ey, ec;
    drawHomebase = 1'b1;
    collect(1000);
    n = qx.size();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 320) begin ex = i % 160; ey = 118 + i / 160; ec = 2; end
      else begin ex = 76 + (i - 320) % 8; ey = 112 + (i - 320) / 8; ec = 7; end
      if (qx[i] != ex || qy[i] != ey || qc[i] != ec || qcyc[i] != i + 2) bad++;
    end
    checks++; if (n != 352) begin errors++; $display("FAIL base_count: got %0d want 352", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL base_stream: %0d pixels wrong, want 0", bad); end
    if (n > 0) begin
      checks++; if (ack_cyc != qcyc[n-1] + 1) begin
        errors++; $display("FAIL base_ack_time: got cycle %0d want %0d", ack_cyc, qcyc[n-1] + 1);
      end
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL base_busy: %0d cycles busy!=plot, want 0", busy_bad); end
    repeat (3) @(negedge clk);
    checks++; if (drewHomebase !== 1'b1) begin errors++; $display("FAIL base_ack_hold: got %b want 1", drewHomebase); end
    checks++; if (rocket_x !== 8'd76) begin errors++; $display("FAIL base_rocket_x: got %0d want 76", rocket_x); end
    drawHomebase = 1'b0;
    @(negedge clk);
    checks++; if (drewHomebase !== 1'b0) begin errors++; $display("FAIL base_ack_drop: got %b want 0", drewHomebase); end
    @(negedge clk);
  endtask

  task automatic test_move_left();
    int bad;
    int n;
    int ex, ec;
    moveLeft = 1'b1;
    collect(200);
    n = qx.size();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 32) begin ex = 76 + i % 8; ec = 0; end
      else begin ex = 74 + (i - 32) % 8; ec = 7; end
      if (qx[i] != ex || qy[i] != 112 + (i % 32) / 8 || qc[i] != ec || qcyc[i] != i + 2) bad++;
    end
    checks++; if (n != 64) begin errors++; $display("FAIL move_count: got %0d want 64", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL move_stream: %0d pixels wrong, want 0", bad); end
    checks++; if (ack_cyc != 66) begin errors++; $display("FAIL move_done_time: got cycle %0d want 66", ack_cyc); end
    checks++; if (rocket_x !== 8'd74) begin errors++; $display("FAIL move_rocket_x: got %0d want 74", rocket_x); end
    @(negedge clk);
    checks++; if (moveDone !== 1'b0) begin errors++; $display("FAIL move_done_pulse: got %b want 0", moveDone); end
  endtask

  task automatic test_edges();
    int rx;
    int old;
    rx = 74;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      old = rx;
      if (k < 40) begin rx = (rx >= 2) ? rx - 2 : 0; moveLeft = 1'b1; end
      else begin rx = (rx + 2 > 152) ? 152 : rx + 2; moveRight = 1'b1; end
      collect(200);
      checks++; if (qx.size() != ((old == rx) ? 0 : 64)) begin
        errors++; $display("FAIL edge_plots[%0d]: got %0d want %0d", k, qx.size(), (old == rx) ? 0 : 64);
      end
      checks++; if (int'(rocket_x) != rx) begin
        errors++; $display("FAIL edge_rocket_x[%0d]: got %0d want %0d", k, rocket_x, rx);
      end
      if (old == rx) begin
        checks++; if (ack_cyc != 1) begin errors++; $display("FAIL edge_done_time[%0d]: got %0d want 1", k, ack_cyc); end
      end
      if (k == 39) begin
        checks++; if (rocket_x !== 8'd0) begin errors++; $display("FAIL edge_left_sat: got %0d want 0", rocket_x); end
      end
    end
    checks++; if (rocket_x !== 8'd152) begin errors++; $display("FAIL edge_right_sat: got %0d want 152", rocket_x); end
    @(negedge clk);
  endtask

  task automatic test_both();
    int act;
    act = 0;
    moveLeft = 1'b1; moveRight = 1'b1;
    @(negedge clk);
    moveLeft = 1'b0; moveRight = 1'b0;
    if (plot !== 1'b0 || moveDone !== 1'b0 || busy !== 1'b0) act++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (plot !== 1'b0 || moveDone !== 1'b0 || busy !== 1'b0) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL both_ignored: %0d active cycles, want 0", act); end
    checks++; if (rocket_x !== 8'd152) begin errors++; $display("FAIL both_rocket_x: got %0d want 152", rocket_x); end
  endtask

  task automatic test_drop_busy();
    int act;
    act = 0;
    moveLeft = 1'b1;
    @(negedge clk);
    moveLeft = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_high: got %b want 1", busy); end
    moveRight = 1'b1;
    collect(200);
    checks++; if (rocket_x !== 8'd150) begin errors++; $display("FAIL drop_rocket_x: got %0d want 150", rocket_x); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (plot !== 1'b0 || moveDone !== 1'b0) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL drop_extra_move: %0d active cycles, want 0", act); end
  endtask

  task automatic test_clear_mid_draw();
    int seen;
    int bad;
    int n;
    seen = 0;
    moveRight = 1'b1;
    @(negedge clk);
    moveRight = 1'b0;
    for (int i = 0; i < 100 && seen < 40; i++) begin
      @(negedge clk);
      if (plot === 1'b1) seen++;
    end
    checks++; if (seen != 40) begin errors++; $display("FAIL abort_setup: saw %0d plots want 40", seen); end
    clearEnable = 1'b1;
    collect(20000);
    n = qx.size();
    bad = 0;
    for (int i = 0; i < n; i++)
      if (qx[i] != i % 160 || qy[i] != i / 160 || qc[i] != 0 || qcyc[i] != i + 2) bad++;
    if (n > 0) begin
      checks++; if (qx[0] != 0 || qy[0] != 0 || qc[0] != 0) begin
        errors++; $display("FAIL abort_first_plot: got %0d,%0d c%0d want 0,0 c0", qx[0], qy[0], qc[0]);
      end
    end
    checks++; if (n != 19200) begin errors++; $display("FAIL abort_clear_count: got %0d want 19200", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_clear_stream: %0d pixels wrong, want 0", bad); end
    checks++; if (rocket_x !== 8'd152) begin errors++; $display("FAIL abort_rocket_x: got %0d want 152", rocket_x); end
    clearEnable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    clearEnable = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (plot !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: plot %b want 1", plot); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_plot: plot %b busy %b want 0 0", plot, busy); end
    checks++; if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
      errors++; $display("FAIL rst_mid_pixel: got %0d,%0d c%b want 0,0 c000", x, y, colour);
    end
    checks++; if ({screenCleared, drewHomebase, moveDone} !== 3'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 000", {screenCleared, drewHomebase, moveDone});
    end
    checks++; if (rocket_x !== 8'd76) begin errors++; $display("FAIL rst_mid_rocket_x: got %0d want 76", rocket_x); end
    clearEnable = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet: plot %b want 0", plot); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_homebase();
    test_move_left();
    test_edges();
    test_both();
    test_drop_busy();
    test_clear_mid_draw();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
